// File: rtl/cordic_vectoring_if.sv
// Handshake and data bundle for the CORDIC vectoring engine: vector in, magnitude/angle out.
// The master drives vectors and accepts results; the slave is the CORDIC block.
interface cordic_vectoring_if #(
  parameter int WORD_LENGTH = 21
);
  logic                          valid_i;
  logic                          ready_o;
  logic signed [WORD_LENGTH-1:0] x_i;
  logic signed [WORD_LENGTH-1:0] y_i;
  logic                          valid_o;
  logic                          ready_i;
  logic signed [WORD_LENGTH-1:0] magnitude_o;
  logic signed [WORD_LENGTH-1:0] angle_o;

  modport master (
    output valid_i, x_i, y_i, ready_i,
    input  ready_o, valid_o, magnitude_o, angle_o
  );

  modport slave (
    input  valid_i, x_i, y_i, ready_i,
    output ready_o, valid_o, magnitude_o, angle_o
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: one micro-rotation per clock, returns the
// gain-scaled magnitude and atan2(y,x) of the accepted vector.
module cordic_vectoring #(
  parameter int WORD_LENGTH  = 21,
  parameter int N_ITERATIONS = 17,
  parameter int FRAC_BITS    = 18
) (
  input  logic               clk,
  input  logic               rst,
  cordic_vectoring_if.slave  bus
);

  localparam int CW = (N_ITERATIONS > 1) ? $clog2(N_ITERATIONS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N_ITERATIONS - 1);

  function automatic int round_fixed(input real r);
    return $rtoi(r * (2.0 ** FRAC_BITS) + 0.5);
  endfunction

  localparam int HALF_PI_INT = round_fixed(2.0 * $atan(1.0));
  localparam logic signed [WORD_LENGTH-1:0] HALF_PI = WORD_LENGTH'(HALF_PI_INT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [WORD_LENGTH-1:0] x_q, x_d;
  logic signed [WORD_LENGTH-1:0] y_q, y_d;
  logic signed [WORD_LENGTH-1:0] z_q, z_d;
  logic signed [WORD_LENGTH-1:0] mag_q, mag_d;
  logic signed [WORD_LENGTH-1:0] ang_q, ang_d;
  logic [CW-1:0]                 iter_q, iter_d;
  logic                          zero_q, zero_d;

  logic signed [WORD_LENGTH-1:0] alpha_tbl [N_ITERATIONS];
  logic signed [WORD_LENGTH-1:0] x_sh, y_sh;
  logic signed [WORD_LENGTH-1:0] x_step, y_step, z_step;

  // Elementary rotation angles atan(2^-i), rounded to the data word's fraction.
  for (genvar gi = 0; gi < N_ITERATIONS; gi++) begin : g_alpha
    localparam int ALPHA_INT = round_fixed($atan(1.0 / (2.0 ** gi)));
    assign alpha_tbl[gi] = WORD_LENGTH'(ALPHA_INT);
  end

  // One micro-rotation driving y towards zero; both updates use pre-update x,y.
  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!y_q[WORD_LENGTH-1]) begin
      x_step = x_q + y_sh;
      y_step = y_q - x_sh;
      z_step = z_q + alpha_tbl[iter_q];
    end else begin
      x_step = x_q - y_sh;
      y_step = y_q + x_sh;
      z_step = z_q - alpha_tbl[iter_q];
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          state_d = ITER;
          iter_d  = '0;
          zero_d  = (bus.x_i == '0) && (bus.y_i == '0);
          // Fold left-half-plane vectors into the right half so the rotations converge.
          if (!bus.x_i[WORD_LENGTH-1]) begin
            x_d = bus.x_i;
            y_d = bus.y_i;
            z_d = '0;
          end else if (!bus.y_i[WORD_LENGTH-1]) begin
            x_d = bus.y_i;
            y_d = -bus.x_i;
            z_d = HALF_PI;
          end else begin
            x_d = -bus.y_i;
            y_d = bus.x_i;
            z_d = -HALF_PI;
          end
        end
      end
      ITER: begin
        x_d    = x_step;
        y_d    = y_step;
        z_d    = z_step;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = DONE;
          mag_d   = zero_q ? '0 : x_step;
          ang_d   = zero_q ? '0 : z_step;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      ang_q   <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.valid_o     = (state_q == DONE);
  assign bus.magnitude_o = mag_q;
  assign bus.angle_o     = ang_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: expected results queue up as vectors are
// sent and are checked against the DUT when valid_o appears.
module tb_cordic_vectoring;

  localparam int W = 21;
  localparam int N = 17;
  localparam int F = 18;

  typedef struct {
    longint mag;
    longint ang;
    longint tol_m;
    longint tol_a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vectoring_if #(.WORD_LENGTH(W)) bus ();

  cordic_vectoring #(
    .WORD_LENGTH (W),
    .N_ITERATIONS(N),
    .FRAC_BITS   (F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  real    gain_k;

  function automatic exp_t mk(input longint m, input longint a, input longint tm, input longint ta);
    exp_t e;
    e.mag   = m;
    e.ang   = a;
    e.tol_m = tm;
    e.tol_a = ta;
    return e;
  endfunction

  // Ideal floating-point reference: gain-scaled length and atan2 in fixed point.
  function automatic exp_t model(input int x, input int y, input longint tm, input longint ta);
    exp_t e;
    real  m;
    real  a;
    m = gain_k * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    a = $atan2(real'(y), real'(x)) * (2.0 ** F);
    e.mag   = longint'($rtoi(m + 0.5));
    e.ang   = (a >= 0.0) ? longint'($rtoi(a + 0.5)) : -longint'($rtoi(-a + 0.5));
    e.tol_m = tm;
    e.tol_a = ta;
    return e;
  endfunction

  task automatic chk_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [63:0] obs,
                          input longint exp, input longint tol);
    logic signed [63:0] d;
    logic ok;
    d  = obs - exp;
    if (d < 0) d = -d;
    ok = (d <= tol);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input int x, input int y, input exp_t e);
    int guard;
    guard = 0;
    while (bus.ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk_eq("ready_before_send", 64'(bus.ready_o), 64'(1));
    bus.x_i     = W'(x);
    bus.y_i     = W'(y);
    bus.valid_i = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (bus.valid_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk_eq("latency", 64'(lat), 64'(N));
    chk_near("magnitude", 64'(bus.magnitude_o), e.mag, e.tol_m);
    chk_near("angle", 64'(bus.angle_o), e.ang, e.tol_a);
    $display("txn: mag=%0d (exp %0d) ang=%0d (exp %0d) lat=%0d",
             bus.magnitude_o, e.mag, bus.angle_o, e.ang, lat);
    for (int h = 0; h < hold; h++) begin
      bus.valid_i = ~bus.valid_i;
      bus.x_i     = W'(h * 1000 + 7);
      @(negedge clk);
      chk_eq("hold_valid", 64'(bus.valid_o), 64'(1));
      chk_eq("hold_ready", 64'(bus.ready_o), 64'(0));
      chk_near("hold_magnitude", 64'(bus.magnitude_o), e.mag, e.tol_m);
      chk_near("hold_angle", 64'(bus.angle_o), e.ang, e.tol_a);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    chk_eq("return_idle_ready", 64'(bus.ready_o), 64'(1));
    chk_eq("return_idle_valid", 64'(bus.valid_o), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    gain_k = 1.0;
    for (int i = 0; i < N; i++) gain_k = gain_k * $sqrt(1.0 + 2.0 ** (-2 * i));

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.x_i     = '0;
    bus.y_i     = '0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("reset_ready", 64'(bus.ready_o), 64'(1));
    chk_eq("reset_valid", 64'(bus.valid_o), 64'(0));
    chk_eq("reset_magnitude", 64'(bus.magnitude_o), 64'(0));
    chk_eq("reset_angle", 64'(bus.angle_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    send(262144, 0, mk(431687, 0, 16, 16));             collect(0);
    send(0, 262144, mk(431687, 411775, 16, 16));        collect(0);
    send(-262144, 0, mk(431687, 823550, 16, 16));       collect(0);
    send(-262144, -1, mk(431687, -823550, 16, 16));     collect(0);
    send(0, 0, mk(0, 0, 0, 0));                          collect(0);
    send(131072, -131072, model(131072, -131072, 32, 16)); collect(5);
    send(-100000, 150000, model(-100000, 150000, 32, 16)); collect(0);
    send(-200000, -60000, model(-200000, -60000, 32, 16)); collect(0);

    // Abort a transaction mid-flight with an asynchronous reset pulse.
    bus.x_i     = W'(100000);
    bus.y_i     = W'(50000);
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (8) @(negedge clk);
    chk_eq("pre_abort_ready", 64'(bus.ready_o), 64'(0));
    #1;
    rst = 1'b1;
    #1;
    chk_eq("abort_ready", 64'(bus.ready_o), 64'(1));
    chk_eq("abort_valid", 64'(bus.valid_o), 64'(0));
    chk_eq("abort_magnitude", 64'(bus.magnitude_o), 64'(0));
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.valid_o !== 1'b0) seen++;
    end
    chk_eq("abort_no_result", 64'(seen), 64'(0));
    $display("txn: abort at iteration 8, valid_o seen %0d times", seen);

    send(185364, 185364, mk(431687, 205887, 16, 16));   collect(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
